instruction_fetch: RTL and testbench

Instruction fetch stage that drives the 16-bit address into the combinational instruction ROM and captures the returned 28-bit instruction word. It keeps the program counter, splits the word into opcode, register and immediate fields, and presents them to the execute stage through a valid/ready handshake. It also accepts a branch redirect from execute.

---
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Purpose: fetch stage; drives the PC into a combinational ROM, captures and splits the 28-bit word (redirect port active with FETCH_REDIRECT_EN).
// Latency: one cycle from PC on oAddress to registered fields with oValid; one-cycle bubble after a redirect.
// Backpressure: oValid && !iReady freezes the PC and every output until the instruction is accepted.
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              iEnable,
    output logic [ADDR_W-1:0] oAddress,
    input  logic [27:0]       iInstruction,
    output logic              oValid,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oPC,
    output logic [3:0]        oOpcode,
    output logic [7:0]        oDest,
    output logic [7:0]        oSrc1,
    output logic [7:0]        oSrc0,
    output logic [15:0]       oImm,
    input  logic              iBranchTaken,
    input  logic [ADDR_W-1:0] iBranchTarget
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              slot_free;
    logic              accept;
    logic              fetch;

`ifdef FETCH_REDIRECT_EN
    assign redirect = iBranchTaken;
`else
    // Redirect ports stay on the interface but carry no function in this build.
    logic unused_branch;
    assign unused_branch = ^{iBranchTaken, iBranchTarget};
    assign redirect      = 1'b0;
`endif

    assign slot_free = !oValid || iReady;
    assign accept    = oValid && iReady;
    assign oAddress  = pc;

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and fetch decision; a redirect suppresses the fetch and only collapses DRAIN.
    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        if (redirect) begin
            if (state == DRAIN) begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (iEnable) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (iEnable) begin
                        fetch = slot_free;
                    end else begin
                        state_nxt = slot_free ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (iEnable) begin
                        state_nxt = RUN;
                    end else if (accept) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // PC and output slot: redirect beats fetch, fetch beats plain acceptance.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc      <= RESET_PC;
            oValid  <= 1'b0;
            oPC     <= '0;
            oOpcode <= '0;
            oDest   <= '0;
            oSrc1   <= '0;
            oSrc0   <= '0;
            oImm    <= '0;
        end else if (redirect) begin
            pc     <= iBranchTarget;
            oValid <= 1'b0;
        end else if (fetch) begin
            pc      <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            oValid  <= 1'b1;
            oPC     <= pc;
            oOpcode <= iInstruction[27:24];
            oDest   <= iInstruction[23:16];
            oSrc1   <= iInstruction[15:8];
            oSrc0   <= iInstruction[7:0];
            oImm    <= iInstruction[15:0];
        end else if (accept) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, wrap and async-reset sequences, random run against a reference model.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: iReady is driven from the table and randomly.
module tb_instruction_fetch;

`ifdef FETCH_REDIRECT_EN
    localparam bit REDIR = 1'b1;
`else
    localparam bit REDIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, rdy, br;
    logic [15:0] tgt;
    logic [15:0] addr, opc;
    logic [27:0] instr;
    logic        vld;
    logic [3:0]  opcode;
    logic [7:0]  dest, src1, src0;
    logic [15:0] imm;

    logic        en2, rdy2;
    logic [15:0] w_addr, w_pc;
    logic [27:0] w_instr;
    logic        w_vld;
    logic [3:0]  w_opcode;
    logic [7:0]  w_dest, w_src1, w_src0;
    logic [15:0] w_imm;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Arbitrary but distinct ROM contents; address 4 holds the known word.
    function automatic logic [27:0] rom(input logic [15:0] a);
        if (a == 16'd4) return {4'h1, 8'd3, 16'd5};
        return {a[3:0] + 4'h7, a[15:8] ^ 8'hA5, a[7:0] ^ 8'h3C, ~a[7:0] + a[15:8]};
    endfunction

    assign instr   = rom(addr);
    assign w_instr = rom(w_addr);

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .Clock(clk), .Reset_n(rst_n), .iEnable(en), .oAddress(addr),
        .iInstruction(instr), .oValid(vld), .iReady(rdy), .oPC(opc),
        .oOpcode(opcode), .oDest(dest), .oSrc1(src1), .oSrc0(src0), .oImm(imm),
        .iBranchTaken(br), .iBranchTarget(tgt)
    );

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .Clock(clk), .Reset_n(rst_n), .iEnable(en2), .oAddress(w_addr),
        .iInstruction(w_instr), .oValid(w_vld), .iReady(rdy2), .oPC(w_pc),
        .oOpcode(w_opcode), .oDest(w_dest), .oSrc1(w_src1), .oSrc0(w_src0), .oImm(w_imm),
        .iBranchTaken(1'b0), .iBranchTarget(16'h0000)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        br;
        logic [15:0] tgt;
        logic        vld;
        logic [15:0] pc;
        logic [15:0] addr;
    } vec_t;

    vec_t tbl[21];

    // Reference model state: "armed" is whether the fetcher was enabled on the previous edge.
    logic        m_vld, m_armed;
    logic [15:0] m_pc, m_opc;
    logic [27:0] m_word;

    initial begin
        logic [15:0] p;
        logic [27:0] w;

        p = REDIR ? 16'h0100 : 16'h0009;
        //            en    rdy   br    tgt       vld     pc                          addr
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,   16'h0000,                   16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0000,                   16'h0001};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0001,                   16'h0002};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0002,                   16'h0003};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0003,                   16'h0004};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0004,                   16'h0005};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0005,                   16'h0006};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0006,                   16'h0007};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1,   16'h0006,                   16'h0007};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1,   16'h0006,                   16'h0007};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1,   16'h0006,                   16'h0007};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   16'h0007,                   16'h0008};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 16'h0100, !REDIR, REDIR ? 16'h0007 : 16'h0008, REDIR ? 16'h0100 : 16'h0009};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   p,                          p + 16'd1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1,   p,                          p + 16'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1,   p,                          p + 16'd1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1,   p,                          p + 16'd1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,   p,                          p + 16'd1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,   p,                          p + 16'd1};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,   p,                          p + 16'd1};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1,   p + 16'd1,                  p + 16'd2};

        // Reset held with enable high: nothing may fetch.
        rst_n = 1'b0; en = 1'b1; rdy = 1'b1; br = 1'b0; tgt = '0;
        en2 = 1'b0; rdy2 = 1'b1;
        step(); step(); step();
        chk("reset_outputs", {3'b0, vld, addr, opc, opcode, dest, src1, src0, imm}, 80'd0);
        chk("reset_wrap_addr", {64'd0, w_addr}, {64'd0, 16'hFFFF});
        chk("reset_wrap_valid", {79'd0, w_vld}, 80'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            en = tbl[i].en; rdy = tbl[i].rdy; br = tbl[i].br; tgt = tbl[i].tgt;
            step();
            chk($sformatf("vec%0d_vld_pc_addr", i), {47'd0, vld, opc, addr},
                {47'd0, tbl[i].vld, tbl[i].pc, tbl[i].addr});
            if (tbl[i].vld) begin
                w = rom(tbl[i].pc);
                chk($sformatf("vec%0d_fields", i), {36'd0, opcode, dest, src1, src0, imm},
                    {36'd0, w[27:24], w[23:16], w[15:8], w[7:0], w[15:0]});
            end
            if (i == 5)
                chk("rom4_decode", {52'd0, opcode, dest, imm}, {52'd0, 4'h1, 8'd3, 16'd5});
        end

        // Wrap: PC FFFF is fetched, then 0000 with no flag.
        en = 1'b0; rdy = 1'b1; br = 1'b0;
        en2 = 1'b1; rdy2 = 1'b1;
        step();
        chk("wrap_edge1", {63'd0, w_vld, w_addr}, {63'd0, 1'b0, 16'hFFFF});
        step();
        chk("wrap_edge2", {47'd0, w_vld, w_pc, w_addr}, {47'd0, 1'b1, 16'hFFFF, 16'h0000});
        step();
        chk("wrap_edge3", {47'd0, w_vld, w_pc, w_addr}, {47'd0, 1'b1, 16'h0000, 16'h0001});
        en2 = 1'b0;

        // Build up a stalled valid output, then reset asynchronously between edges.
        en = 1'b1; rdy = 1'b0;
        step(); step(); step();
        chk("pre_async_valid", {79'd0, vld}, {79'd0, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {3'b0, vld, addr, opc, opcode, dest, src1, src0, imm}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        m_vld = 1'b0; m_armed = 1'b0; m_pc = 16'h0000; m_opc = 16'h0000; m_word = '0;
        for (int c = 0; c < 3000; c++) begin
            logic redir, fetch;
            en  = ($urandom % 8) != 0;
            rdy = ($urandom % 4) != 0;
            br  = ($urandom % 16) == 0;
            tgt = 16'($urandom);
            @(posedge clk);
            redir = REDIR && br;
            fetch = m_armed && en && (!m_vld || rdy) && !redir;
            if (redir) begin
                m_pc  = tgt;
                m_vld = 1'b0;
            end else if (fetch) begin
                m_word = rom(m_pc);
                m_opc  = m_pc;
                m_vld  = 1'b1;
                m_pc   = m_pc + 16'd1;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
            if (!redir) m_armed = en;
            @(negedge clk);
            chk($sformatf("rand%0d", c), {3'b0, vld, addr, opc, opcode, dest, src1, src0, imm},
                {3'b0, m_vld, m_pc, m_opc, m_word[27:24], m_word[23:16], m_word[15:8], m_word[7:0], m_word[15:0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
